// File: rtl/rob_pr_free_q_pkg.sv
// Shared types and sizing for the ROB freed-PR queue that feeds the banked free list.
package rob_pr_free_q_pkg;

  localparam int unsigned LOG_PR_COUNT              = 7;
  localparam int unsigned ROB_PR_FREE_Q_ENTRIES     = 2;
  localparam int unsigned FREE_LIST_BANK_COUNT      = 4;
  localparam int unsigned LOG_FREE_LIST_BANK_COUNT  = 2;
  localparam int unsigned ROB_COMMIT_LANES          = 4;

  typedef logic [LOG_PR_COUNT-1:0] pr_t;

  // One commit bundle: a PR per lane plus the lanes still waiting to drain
  typedef struct packed {
    pr_t [ROB_COMMIT_LANES-1:0]  pr;
    logic [ROB_COMMIT_LANES-1:0] pending;
  } pr_free_bundle_t;

endpackage

// File: rtl/rob_pr_free_q_if.sv
// Commit-side enqueue and free-list drain signals of rob_pr_free_q.
// Carries stall_cycles only when ROB_PR_FREE_Q_STALL_CNT_EN is defined.
interface rob_pr_free_q_if
  import rob_pr_free_q_pkg::*;
#(
  parameter int unsigned PR_FREE_Q_ENTRIES = ROB_PR_FREE_Q_ENTRIES,
  parameter int unsigned LANES             = ROB_COMMIT_LANES,
  parameter int unsigned PR_W              = LOG_PR_COUNT,
  parameter int unsigned BANKS             = FREE_LIST_BANK_COUNT
);
  localparam int unsigned OCC_W = $clog2(PR_FREE_Q_ENTRIES + 1);

  logic                            enq_valid;
  logic [LANES-1:0]                enq_lane_valid;
  logic [LANES-1:0][PR_W-1:0]      enq_lane_PR;
  logic                            enq_ready;
  logic [BANKS-1:0]                free_valid_by_bank;
  logic [BANKS-1:0][PR_W-1:0]      free_PR_by_bank;
  logic [BANKS-1:0]                free_ready_by_bank;
  logic [OCC_W-1:0]                occupancy;
`ifdef ROB_PR_FREE_Q_STALL_CNT_EN
  logic [15:0]                     stall_cycles;

  modport master (
    output enq_valid, enq_lane_valid, enq_lane_PR, free_ready_by_bank,
    input  enq_ready, free_valid_by_bank, free_PR_by_bank, occupancy, stall_cycles
  );
  modport slave (
    input  enq_valid, enq_lane_valid, enq_lane_PR, free_ready_by_bank,
    output enq_ready, free_valid_by_bank, free_PR_by_bank, occupancy, stall_cycles
  );
`else
  modport master (
    output enq_valid, enq_lane_valid, enq_lane_PR, free_ready_by_bank,
    input  enq_ready, free_valid_by_bank, free_PR_by_bank, occupancy
  );
  modport slave (
    input  enq_valid, enq_lane_valid, enq_lane_PR, free_ready_by_bank,
    output enq_ready, free_valid_by_bank, free_PR_by_bank, occupancy
  );
`endif

endinterface

// File: rtl/pr_free_bank_select.sv
// Per-bank picker: for each free-list bank, the lowest pending head lane whose PR maps to it.
module pr_free_bank_select #(
  parameter int unsigned LANES = 4,
  parameter int unsigned PR_W  = 7,
  parameter int unsigned BANKS = 4
) (
  input  logic [LANES-1:0]              i_pend,
  input  logic [LANES-1:0][PR_W-1:0]    i_pr,
  output logic [BANKS-1:0]              o_valid_c,
  output logic [BANKS-1:0][PR_W-1:0]    o_pr_c,
  output logic [BANKS-1:0][LANES-1:0]   o_sel_c
);
  localparam int unsigned BANK_W = $clog2(BANKS);

  // Scan lanes high to low so the lowest matching lane is the last writer
  always_comb begin
    o_valid_c = '0;
    o_pr_c    = '0;
    o_sel_c   = '0;
    for (int b = 0; b < int'(BANKS); b++) begin
      for (int l = int'(LANES) - 1; l >= 0; l--) begin
        if (i_pend[l] && (i_pr[l][BANK_W-1:0] == BANK_W'(b))) begin
          o_valid_c[b]  = 1'b1;
          o_pr_c[b]     = i_pr[l];
          o_sel_c[b]    = '0;
          o_sel_c[b][l] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rob_pr_free_q.sv
// Circular buffer of ROB commit bundles draining freed PRs into the banked free list.
// Optional feature: ROB_PR_FREE_Q_STALL_CNT_EN adds a saturating bank-stall counter.
module rob_pr_free_q
  import rob_pr_free_q_pkg::*;
#(
  parameter int unsigned PR_FREE_Q_ENTRIES = ROB_PR_FREE_Q_ENTRIES,
  parameter int unsigned LANES             = ROB_COMMIT_LANES,
  parameter int unsigned PR_W              = LOG_PR_COUNT,
  parameter int unsigned BANKS             = FREE_LIST_BANK_COUNT
) (
  input  logic             CLK,
  input  logic             nRST,
  rob_pr_free_q_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(PR_FREE_Q_ENTRIES);
  localparam int unsigned OCC_W = $clog2(PR_FREE_Q_ENTRIES + 1);

  logic [PTR_W-1:0]           r_head;
  logic [PTR_W-1:0]           r_tail;
  logic [OCC_W-1:0]           r_occ;
  logic [LANES-1:0][PR_W-1:0] r_pr   [PR_FREE_Q_ENTRIES];
  logic [LANES-1:0]           r_pend [PR_FREE_Q_ENTRIES];

  logic                       w_nonempty;
  logic                       w_full;
  logic                       w_enq;
  logic                       w_retire;
  logic [LANES-1:0]           w_head_pend;
  logic [LANES-1:0]           w_clr;
  logic [LANES-1:0]           w_pend_nxt;
  logic [BANKS-1:0]           w_valid;
  logic [BANKS-1:0][PR_W-1:0] w_pr;
  logic [BANKS-1:0][LANES-1:0] w_sel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PR_FREE_Q_ENTRIES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_nonempty  = (r_occ != '0);
  assign w_full      = (r_occ == OCC_W'(PR_FREE_Q_ENTRIES));
  assign w_head_pend = w_nonempty ? r_pend[r_head] : '0;
  // Bundles with no valid lane are dropped without taking a slot
  assign w_enq       = bus.enq_valid && !w_full && (|bus.enq_lane_valid);

  pr_free_bank_select #(
    .LANES (LANES),
    .PR_W  (PR_W),
    .BANKS (BANKS)
  ) u_bank_select (
    .i_pend    (w_head_pend),
    .i_pr      (r_pr[r_head]),
    .o_valid_c (w_valid),
    .o_pr_c    (w_pr),
    .o_sel_c   (w_sel)
  );

  always_comb begin
    w_clr = '0;
    for (int b = 0; b < int'(BANKS); b++) begin
      if (bus.free_ready_by_bank[b]) w_clr = w_clr | w_sel[b];
    end
  end

  assign w_pend_nxt = w_head_pend & ~w_clr;
  assign w_retire   = w_nonempty && (w_pend_nxt == '0);

  // PR payload needs no reset: it is only read through the pending mask
  always_ff @(posedge CLK) begin
    if (w_enq) r_pr[r_tail] <= bus.enq_lane_PR;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int e = 0; e < int'(PR_FREE_Q_ENTRIES); e++) r_pend[e] <= '0;
    end else begin
      if (w_nonempty) r_pend[r_head] <= w_pend_nxt;
      if (w_enq) begin
        r_pend[r_tail] <= bus.enq_lane_valid;
        r_tail         <= ptr_inc(r_tail);
      end
      if (w_retire) r_head <= ptr_inc(r_head);
      case ({w_enq, w_retire})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.enq_ready          = !w_full;
  assign bus.occupancy          = r_occ;
  assign bus.free_valid_by_bank = w_valid;
  assign bus.free_PR_by_bank    = w_pr;

`ifdef ROB_PR_FREE_Q_STALL_CNT_EN
  logic [15:0] r_stall;
  logic        w_stall;

  assign w_stall = |(w_valid & ~bus.free_ready_by_bank);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                             r_stall <= '0;
    else if (w_stall && (r_stall != '1))   r_stall <= r_stall + 16'd1;
  end

  assign bus.stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_rob_pr_free_q.sv
// Directed bench for rob_pr_free_q: reset, drain ordering, full/empty, head blocking.
module tb_rob_pr_free_q;
  import rob_pr_free_q_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rob_pr_free_q_if bus ();

  rob_pr_free_q dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [3:0] lv, input pr_t p0, input pr_t p1, input pr_t p2, input pr_t p3);
    bus.enq_valid      = 1'b1;
    bus.enq_lane_valid = lv;
    bus.enq_lane_PR    = {p3, p2, p1, p0};
  endtask

  task automatic idle();
    bus.enq_valid      = 1'b0;
    bus.enq_lane_valid = '0;
    bus.enq_lane_PR    = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.free_ready_by_bank = 4'b1111;
    tick();
    tick();
    chk("rst_occ",   32'(bus.occupancy), 32'd0);
    chk("rst_ready", 32'(bus.enq_ready), 32'd1);
    chk("rst_valid", 32'(bus.free_valid_by_bank), 32'd0);
    chk("rst_pr",    32'(bus.free_PR_by_bank), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // distinct banks: all four leave together
    enq(4'b1111, 7'd4, 7'd9, 7'd14, 7'd19);
    tick();
    idle();
    chk("dist_occ",   32'(bus.occupancy), 32'd1);
    chk("dist_valid", 32'(bus.free_valid_by_bank), 32'hF);
    chk("dist_pr",    32'(bus.free_PR_by_bank), 32'({7'd19, 7'd14, 7'd9, 7'd4}));
    tick();
    chk("dist_occ_after",   32'(bus.occupancy), 32'd0);
    chk("dist_valid_after", 32'(bus.free_valid_by_bank), 32'd0);

    // same bank: serialised in lane order
    enq(4'b1111, 7'd8, 7'd12, 7'd16, 7'd20);
    tick();
    idle();
    chk("same_valid0", 32'(bus.free_valid_by_bank), 32'h1);
    chk("same_pr0",    32'(bus.free_PR_by_bank), 32'd8);
    tick();
    chk("same_pr1",    32'(bus.free_PR_by_bank), 32'd12);
    tick();
    chk("same_pr2",    32'(bus.free_PR_by_bank), 32'd16);
    tick();
    chk("same_pr3",    32'(bus.free_PR_by_bank), 32'd20);
    chk("same_occ3",   32'(bus.occupancy), 32'd1);
    tick();
    chk("same_occ_after",   32'(bus.occupancy), 32'd0);
    chk("same_valid_after", 32'(bus.free_valid_by_bank), 32'd0);

    // full: bank 2 blocked with two bank-2 bundles queued
    bus.free_ready_by_bank = 4'b1011;
    enq(4'b0001, 7'd2, 7'd0, 7'd0, 7'd0);
    tick();
    enq(4'b0001, 7'd10, 7'd0, 7'd0, 7'd0);
    tick();
    idle();
    chk("full_occ",   32'(bus.occupancy), 32'd2);
    chk("full_ready", 32'(bus.enq_ready), 32'd0);
    chk("full_valid", 32'(bus.free_valid_by_bank), 32'h4);
    chk("full_pr",    32'(bus.free_PR_by_bank), 32'({7'd0, 7'd2, 7'd0, 7'd0}));
    enq(4'b0001, 7'd1, 7'd0, 7'd0, 7'd0);
    tick();
    idle();
    chk("full_reject_occ", 32'(bus.occupancy), 32'd2);
    bus.free_ready_by_bank = 4'b1111;
    #1;
    chk("full_no_bypass", 32'(bus.enq_ready), 32'd0);
    tick();
    chk("full_occ_ret",   32'(bus.occupancy), 32'd1);
    chk("full_ready_ret", 32'(bus.enq_ready), 32'd1);
    chk("full_pr_next",   32'(bus.free_PR_by_bank), 32'({7'd0, 7'd10, 7'd0, 7'd0}));
    tick();
    chk("full_drained_occ",   32'(bus.occupancy), 32'd0);
    chk("full_drained_valid", 32'(bus.free_valid_by_bank), 32'd0);

    // asynchronous reset mid-drain with both slots full
    bus.free_ready_by_bank = 4'b1011;
    enq(4'b0001, 7'd2, 7'd0, 7'd0, 7'd0);
    tick();
    enq(4'b0001, 7'd10, 7'd0, 7'd0, 7'd0);
    tick();
    idle();
    chk("arst_pre_occ", 32'(bus.occupancy), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ",   32'(bus.occupancy), 32'd0);
    chk("arst_valid", 32'(bus.free_valid_by_bank), 32'd0);
    chk("arst_ready", 32'(bus.enq_ready), 32'd1);
    chk("arst_pr",    32'(bus.free_PR_by_bank), 32'd0);
    bus.free_ready_by_bank = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_post_occ", 32'(bus.occupancy), 32'd0);

    // empty bundle is dropped and leaves the tail in place
    enq(4'b0000, 7'd3, 7'd7, 7'd11, 7'd15);
    tick();
    idle();
    chk("empty_occ",   32'(bus.occupancy), 32'd0);
    chk("empty_valid", 32'(bus.free_valid_by_bank), 32'd0);
    enq(4'b0001, 7'd4, 7'd0, 7'd0, 7'd0);
    tick();
    idle();
    chk("empty_next_valid", 32'(bus.free_valid_by_bank), 32'h1);
    chk("empty_next_pr",    32'(bus.free_PR_by_bank), 32'd4);
    tick();
    chk("empty_next_occ",   32'(bus.occupancy), 32'd0);

    // head blocking: later bundle for an idle bank waits behind PR 5
    bus.free_ready_by_bank = 4'b1101;
    enq(4'b0001, 7'd5, 7'd0, 7'd0, 7'd0);
    tick();
    chk("hb_valid1", 32'(bus.free_valid_by_bank), 32'h2);
    chk("hb_pr1",    32'(bus.free_PR_by_bank), 32'({7'd0, 7'd0, 7'd5, 7'd0}));
    enq(4'b0001, 7'd0, 7'd0, 7'd0, 7'd0);
    tick();
    idle();
    chk("hb_occ2",   32'(bus.occupancy), 32'd2);
    chk("hb_valid2", 32'(bus.free_valid_by_bank), 32'h2);
    tick();
    chk("hb_valid3", 32'(bus.free_valid_by_bank), 32'h2);
    tick();
    chk("hb_valid4", 32'(bus.free_valid_by_bank), 32'h2);
`ifdef ROB_PR_FREE_Q_STALL_CNT_EN
    chk("hb_stall_blocked", 32'(bus.stall_cycles), 32'd3);
`endif
    bus.free_ready_by_bank = 4'b1111;
    tick();
    chk("hb_occ_ret",  32'(bus.occupancy), 32'd1);
    chk("hb_valid_b0", 32'(bus.free_valid_by_bank), 32'h1);
    chk("hb_pr_b0",    32'(bus.free_PR_by_bank), 32'd0);
    tick();
    chk("hb_occ_end",  32'(bus.occupancy), 32'd0);
`ifdef ROB_PR_FREE_Q_STALL_CNT_EN
    chk("hb_stall_end", 32'(bus.stall_cycles), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
